// File: rtl/memwb_elastic_pipe.sv
// Elastic MEM/WB buffer: DEPTH register slices with valid/ready stall, flush and occupancy.
// Legal configurations: 1 <= DEPTH <= 4 and 2**OCC_W > DEPTH.
module memwb_elastic_pipe #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned OCC_W  = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] Ctrl_In,
    input  logic [DATA_W-1:0] Data_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Ctrl_Out,
    output logic [DATA_W-1:0] Data_Out,
    output logic [OCC_W-1:0]  Occupancy
);

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_nxt;
    logic [DEPTH-1:0]  rdy;
    logic [OCC_W-1:0]  occ_nxt;
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Ready ripples from the output side; an empty slice is always ready.
    always_comb begin : ready_chain
        logic chain;
        chain = Out_Ready;
        rdy   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            chain              = ~valid[DEPTH-1-k] | chain;
            rdy[DEPTH-1-k]     = chain;
        end
    end

    always_comb begin
        valid_nxt = valid;
        if (rdy[0]) valid_nxt[0] = In_Valid;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (rdy[k]) valid_nxt[k] = valid[k-1];
        end
        if (Flush) valid_nxt = '0;
    end

    always_comb begin
        occ_nxt = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ_nxt = occ_nxt + OCC_W'(valid_nxt[k]);
        end
    end

    // Flush kills entries but leaves data registers untouched.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid     <= '0;
            Occupancy <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid     <= valid_nxt;
            Occupancy <= occ_nxt;
            if (Flush) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    ctrl_q[k] <= '0;
                end
            end else begin
                if (rdy[0]) begin
                    ctrl_q[0] <= Ctrl_In;
                    data_q[0] <= Data_In;
                end
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    if (rdy[k]) begin
                        ctrl_q[k] <= ctrl_q[k-1];
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

    assign In_Ready  = rdy[0] & ~Flush;
    assign Out_Valid = valid[DEPTH-1];
    assign Ctrl_Out  = Out_Valid ? ctrl_q[DEPTH-1] : '0;
    assign Data_Out  = data_q[DEPTH-1];

endmodule

// File: tb/tb_memwb_elastic_pipe.sv
// Scoreboard bench for memwb_elastic_pipe at DEPTH=3: directed stimulus, decoupled output monitor.
module tb_memwb_elastic_pipe;

    localparam int unsigned CTRL_W = 8;
    localparam int unsigned DATA_W = 96;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned OCC_W  = 3;

    logic              Clock;
    logic              Reset;
    logic              Flush;
    logic              In_Valid;
    logic              In_Ready;
    logic [CTRL_W-1:0] Ctrl_In;
    logic [DATA_W-1:0] Data_In;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [CTRL_W-1:0] Ctrl_Out;
    logic [DATA_W-1:0] Data_Out;
    logic [OCC_W-1:0]  Occupancy;

    memwb_elastic_pipe #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Flush    (Flush),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Ctrl_In  (Ctrl_In),
        .Data_In  (Data_In),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .Ctrl_Out (Ctrl_Out),
        .Data_Out (Data_Out),
        .Occupancy(Occupancy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   armed = 1'b0;
    logic [CTRL_W+DATA_W-1:0] exp_q [$];

    function automatic logic [DATA_W-1:0] mkdata(input logic [7:0] c);
        return {24'hD00D00, c, 32'h89AB_CD00 | {24'h0, c}, ~{24'h0, c}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge Clock);
    endtask

    // Presents an entry that the bench expects to see at the output later.
    task automatic send(input logic [7:0] c);
        In_Valid = 1'b1;
        Ctrl_In  = c;
        Data_In  = mkdata(c);
        exp_q.push_back({c, mkdata(c)});
    endtask

    // Presents an entry that must never be captured.
    task automatic offer(input logic [7:0] c);
        In_Valid = 1'b1;
        Ctrl_In  = c;
        Data_In  = mkdata(c);
    endtask

    task automatic idle(input int n);
        In_Valid = 1'b0;
        repeat (n) begin
            at_neg();
            tick();
        end
    endtask

    always @(negedge Clock) begin
        logic [CTRL_W+DATA_W-1:0] e;
        if (armed) begin
            if (Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got ctrl %0h, expected no entry", Ctrl_Out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_ctrl", 128'(Ctrl_Out), 128'(e[CTRL_W+DATA_W-1:DATA_W]));
                    chk("out_data", 128'(Data_Out), 128'(e[DATA_W-1:0]));
                end
            end
            if (!Out_Valid) chk("ctrl_gated", 128'(Ctrl_Out), 128'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        Reset     = 1'b1;
        Flush     = 1'b0;
        Out_Ready = 1'b1;
        In_Valid  = 1'b1;
        Ctrl_In   = 8'hFF;
        Data_In   = 96'h1;

        // Reset with a valid entry presented
        tick();
        at_neg();
        chk("reset_out_valid", 128'(Out_Valid), 128'(0));
        chk("reset_ctrl_out",  128'(Ctrl_Out),  128'(0));
        chk("reset_data_out",  128'(Data_Out),  128'(0));
        chk("reset_occupancy", 128'(Occupancy), 128'(0));
        tick();
        Reset    = 1'b0;
        In_Valid = 1'b0;
        armed    = 1'b1;

        // Streaming with Out_Ready high
        send(8'h81); at_neg();
        chk("stream_in_ready_0", 128'(In_Ready), 128'(1));
        chk("stream_out_valid_0", 128'(Out_Valid), 128'(0));
        tick();
        send(8'h82); at_neg();
        chk("stream_in_ready_1", 128'(In_Ready), 128'(1));
        chk("stream_out_valid_1", 128'(Out_Valid), 128'(0));
        tick();
        send(8'h83); at_neg();
        chk("stream_in_ready_2", 128'(In_Ready), 128'(1));
        chk("stream_out_valid_2", 128'(Out_Valid), 128'(0));
        tick();
        In_Valid = 1'b0; at_neg();
        chk("stream_latency", 128'(Out_Valid), 128'(1));
        chk("stream_occ_full", 128'(Occupancy), 128'(3));
        tick();
        idle(3); at_neg();
        chk("stream_drained", 128'(Occupancy), 128'(0));
        tick();

        // Stall fill
        Out_Ready = 1'b0;
        send(8'hA1); at_neg(); chk("stall_in_ready_a", 128'(In_Ready), 128'(1)); tick();
        send(8'hB2); at_neg(); chk("stall_in_ready_b", 128'(In_Ready), 128'(1)); tick();
        send(8'hC3); at_neg(); chk("stall_in_ready_c", 128'(In_Ready), 128'(1)); tick();
        send(8'hD4); at_neg();
        chk("stall_in_ready_full", 128'(In_Ready), 128'(0));
        chk("stall_occ_full", 128'(Occupancy), 128'(3));
        chk("stall_head_ctrl", 128'(Ctrl_Out), 128'(8'hA1));
        tick();
        at_neg();
        chk("stall_held", 128'(In_Ready), 128'(0));
        chk("stall_occ_held", 128'(Occupancy), 128'(3));
        tick();
        Out_Ready = 1'b1; at_neg();
        chk("stall_release_in_ready", 128'(In_Ready), 128'(1));
        tick();
        idle(4); at_neg();
        chk("stall_drained", 128'(Occupancy), 128'(0));
        tick();

        // Bubble compression
        Out_Ready = 1'b0;
        send(8'h1A); at_neg(); tick();
        In_Valid = 1'b0; at_neg(); tick();
        send(8'h2B); at_neg();
        chk("bubble_in_ready", 128'(In_Ready), 128'(1));
        tick();
        In_Valid = 1'b0; at_neg();
        chk("bubble_occ", 128'(Occupancy), 128'(2));
        chk("bubble_head", 128'(Ctrl_Out), 128'(8'h1A));
        tick();
        at_neg();
        chk("bubble_occ_compressed", 128'(Occupancy), 128'(2));
        chk("bubble_slot_free", 128'(In_Ready), 128'(1));
        tick();
        send(8'h3C); at_neg(); tick();
        In_Valid = 1'b0; at_neg();
        chk("bubble_no_gap_ready", 128'(In_Ready), 128'(0));
        chk("bubble_no_gap_occ", 128'(Occupancy), 128'(3));
        tick();
        Out_Ready = 1'b1;
        idle(4); at_neg();
        chk("bubble_drained", 128'(Occupancy), 128'(0));
        tick();

        // Flush with a full chain and an entry presented
        Out_Ready = 1'b0;
        send(8'hE1); tick();
        send(8'hE2); tick();
        send(8'hE3); tick();
        offer(8'h99);
        Flush = 1'b1; at_neg();
        chk("flush_in_ready", 128'(In_Ready), 128'(0));
        chk("flush_out_valid_during", 128'(Out_Valid), 128'(1));
        tick();
        Flush    = 1'b0;
        In_Valid = 1'b0;
        exp_q.delete();
        at_neg();
        chk("flush_out_valid", 128'(Out_Valid), 128'(0));
        chk("flush_ctrl_out",  128'(Ctrl_Out),  128'(0));
        chk("flush_occ",       128'(Occupancy), 128'(0));
        chk("flush_data_held", 128'(Data_Out),  128'(mkdata(8'hE1)));
        tick();
        Out_Ready = 1'b1;
        idle(4); at_neg();
        chk("flush_not_captured", 128'(Occupancy), 128'(0));
        tick();

        // Reset and Flush together on a stalled full chain
        Out_Ready = 1'b0;
        send(8'hF1); tick();
        send(8'hF2); tick();
        send(8'hF3); tick();
        offer(8'h77);
        Reset = 1'b1;
        Flush = 1'b1;
        at_neg(); tick();
        Reset    = 1'b0;
        Flush    = 1'b0;
        In_Valid = 1'b0;
        exp_q.delete();
        at_neg();
        chk("rstflush_out_valid", 128'(Out_Valid), 128'(0));
        chk("rstflush_ctrl_out",  128'(Ctrl_Out),  128'(0));
        chk("rstflush_data_out",  128'(Data_Out),  128'(0));
        chk("rstflush_occ",       128'(Occupancy), 128'(0));
        tick();
        Out_Ready = 1'b1;
        send(8'h55); at_neg(); tick();
        In_Valid = 1'b0;
        n = 1;
        while (n < 10) begin
            at_neg();
            if (Out_Valid) break;
            tick();
            n++;
        end
        chk("rstflush_latency", 128'(n), 128'(DEPTH));
        tick();
        idle(3);

        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/memwb_elastic_pipe.md
Name: memwb_elastic_pipe

Overview:
- Parametrised successor to the fixed MEM/WB stage register.
- A configurable-depth chain of pipeline register slices. Each slice carries a control field and a data field plus a valid bit.
- Supports a valid/ready handshake (stall), flush with bubble insertion, and an occupancy count.
- Sits between MEM and WB, or between any two pipeline stages needing stall/flush-capable buffering.

Parameters:
- CTRL_W, 8, width of control bundle (e.g. MemToReg[1:0], RegDest[4:0], RegWrite).
- DATA_W, 96, width of data bundle (e.g. ALUResult, PC, ReadData concatenated).
- DEPTH, 1, number of register slices; legal range 1..4.
- OCC_W, 3, occupancy width; must satisfy 2^OCC_W > DEPTH.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; clears all slices.
- Flush  in  1  kill all in-flight entries (bubble insertion).
- In_Valid  in  1  upstream presents an entry.
- In_Ready  out  1  this block accepts the entry this cycle.
- Ctrl_In  in  CTRL_W  control bundle in.
- Data_In  in  DATA_W  data bundle in.
- Out_Valid  out  1  slice DEPTH-1 holds a valid entry.
- Out_Ready  in  1  downstream accepts; low = stall.
- Ctrl_Out  out  CTRL_W  control bundle out; forced 0 when Out_Valid=0.
- Data_Out  out  DATA_W  data bundle out; raw register value.
- Occupancy  out  OCC_W  number of valid slices, 0..DEPTH.

Behaviour:
- One clock (Clock); reset is synchronous and active-high (Reset); no asynchronous paths.
- Reset (sampled at posedge):
  - all valid bits = 0, all ctrl registers = 0, all data registers = 0.
  - Hence Out_Valid=0, Ctrl_Out=0, Data_Out=0, Occupancy=0 in the following cycle.
- Reset has priority over Flush and over all handshakes. Reset mid-stall discards all content.
- Slices are indexed 0 (input side) .. DEPTH-1 (output side).
- Ready chain (combinational):
  - rdy[DEPTH] = Out_Ready.
  - rdy[i] = ~valid[i] | rdy[i+1].
  - In_Ready = rdy[0] & ~Flush.
- Advance (per posedge, no Reset, no Flush):
  - If rdy[i]=1, slice i loads from its upstream source: slice i-1 for i>0, else the In_* ports.
  - Loaded valid = In_Valid for slice 0, valid[i-1] for i>0.
  - If rdy[i]=0, slice i holds all fields.
- Ctrl/data registers load even when the incoming valid is 0. Ctrl is then irrelevant because output gating forces it to 0.
- Input transfer occurs iff In_Valid & In_Ready. Output transfer occurs iff Out_Valid & Out_Ready.
- Timing: latency is DEPTH cycles from input transfer to Out_Valid with Out_Ready held high. Throughput is 1 entry/cycle sustained.
- Stall: with Out_Ready=0 the chain fills.
  - In_Ready drops once all DEPTH slices are valid; upstream must hold In_* stable until accepted.
  - Bubbles compress: an invalid slice accepts even when downstream is stalled.
- Flush (sampled at posedge, no Reset):
  - all valid bits = 0 and all ctrl registers = 0; data registers hold.
  - In_Ready=0 during a Flush cycle, so In_Valid on that cycle is not accepted and is lost unless upstream re-presents it.
  - Out_Valid may still be 1 in the Flush cycle. Downstream may consume that entry; it is the last pre-flush entry.
- Occupancy: registered, updated each posedge, equal to the popcount of the next valid vector. Reset and Flush give 0. Never exceeds DEPTH.
- Simultaneous input and output transfer on a full chain (Out_Ready=1) leaves Occupancy unchanged.
- DEPTH=1 with Out_Ready tied high and In_Valid tied high behaves as a plain MEM/WB register with reset.

Test Plan:
- Reset: drive Reset=1 for 2 cycles with In_Valid=1, Ctrl_In=8'hFF, Data_In=96'h1 -> Out_Valid=0, Ctrl_Out=0, Data_Out=0, Occupancy=0 after the first posedge.
- Streaming, DEPTH=3, Out_Ready=1: push ctrl 8'h81, 8'h82, 8'h83 on consecutive cycles -> Out_Valid rises 3 cycles after the first push; outputs 81, 82, 83 on consecutive cycles; In_Ready stays 1.
- Stall fill, DEPTH=3: Out_Ready=0, push 4 entries A..D -> In_Ready=0 after A,B,C are accepted, Occupancy=3, D held. Raise Out_Ready -> A, B, C, D emerge in order with no loss or duplication.
- Bubble compression, DEPTH=3: push A, idle 1 cycle, push B with Out_Ready=0 -> Occupancy=2, and A and B end in slices 2 and 1 with no gap.
- Flush: with 3 valid entries, assert Flush for 1 cycle with In_Valid=1 -> In_Ready=0 in that cycle; next cycle Out_Valid=0, Ctrl_Out=0, Occupancy=0; the input entry is not captured.
- Reset vs Flush vs stall: Reset=1 and Flush=1 together with Out_Ready=0 on a full chain -> all state cleared exactly as for Reset. A subsequent push of ctrl 8'h55 appears at the output after DEPTH cycles.
